// File: rtl/dds_chirp_core.sv
// Linear-FM DDS core: REQ/ACK capture into shadow registers, activated on DDS_start rise,
// 48-bit phase accumulator with frequency stepped by delta_freq every delta_rate clocks.
//
// state  | meaning
// H_IDLE | waiting for REQ; captures the DDS_* buses when it rises
// H_ACK  | ACK held high until the sequencer drops REQ
module dds_chirp_core (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  output logic        ACK,
  input  logic [47:0] DDS_freq,
  input  logic [47:0] DDS_delta_freq,
  input  logic [31:0] DDS_delta_rate,
  input  logic        DDS_start,
  output logic [15:0] PHASE_OUT,
  output logic [47:0] FREQ_CUR,
  output logic        RUNNING,
  output logic        SWEEP_TICK
);

  typedef enum logic {H_IDLE = 1'b0, H_ACK = 1'b1} hs_state_t;

  hs_state_t   hs_state, hs_next;
  logic        ack_next;
  logic        capture;

  logic [47:0] shadow_freq, shadow_delta;
  logic [31:0] shadow_rate;
  logic [47:0] act_delta;
  logic [31:0] act_rate;
  logic [31:0] cnt;
  logic [47:0] phase_acc;
  logic        start_d;
  logic        start_rise;
  logic        step_now;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hs_state <= H_IDLE;
      ACK      <= 1'b0;
    end else begin
      hs_state <= hs_next;
      ACK      <= ack_next;
    end
  end

  always_comb begin
    hs_next  = hs_state;
    ack_next = ACK;
    capture  = 1'b0;
    case (hs_state)
      H_IDLE: begin
        if (REQ) begin
          capture  = 1'b1;
          ack_next = 1'b1;
          hs_next  = H_ACK;
        end
      end
      H_ACK: begin
        if (!REQ) begin
          ack_next = 1'b0;
          hs_next  = H_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_freq  <= '0;
      shadow_delta <= '0;
      shadow_rate  <= '0;
    end else if (capture) begin
      shadow_freq  <= DDS_freq;
      shadow_delta <= DDS_delta_freq;
      shadow_rate  <= DDS_delta_rate;
    end
  end

  assign start_rise = DDS_start && !start_d;
  assign step_now   = (act_rate != 32'd0) && (cnt == act_rate - 32'd1);

  // Active registers load from shadow only on a rising edge, so a capture in the
  // same cycle as the edge still sees the previous shadow contents.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_d    <= 1'b0;
      phase_acc  <= '0;
      FREQ_CUR   <= '0;
      act_delta  <= '0;
      act_rate   <= '0;
      cnt        <= '0;
      RUNNING    <= 1'b0;
      SWEEP_TICK <= 1'b0;
    end else begin
      start_d <= DDS_start;
      if (start_rise) begin
        phase_acc  <= '0;
        FREQ_CUR   <= shadow_freq;
        act_delta  <= shadow_delta;
        act_rate   <= shadow_rate;
        cnt        <= '0;
        RUNNING    <= 1'b1;
        SWEEP_TICK <= 1'b0;
      end else if (DDS_start) begin
        phase_acc <= phase_acc + FREQ_CUR;
        if (act_rate == 32'd0) begin
          cnt        <= '0;
          SWEEP_TICK <= 1'b0;
        end else if (step_now) begin
          FREQ_CUR   <= FREQ_CUR + act_delta;
          cnt        <= '0;
          SWEEP_TICK <= 1'b1;
        end else begin
          cnt        <= cnt + 32'd1;
          SWEEP_TICK <= 1'b0;
        end
      end else begin
        RUNNING    <= 1'b0;
        phase_acc  <= '0;
        cnt        <= '0;
        SWEEP_TICK <= 1'b0;
      end
    end
  end

  assign PHASE_OUT = phase_acc[47:32];

endmodule

// File: tb/tb_dds_chirp_core.sv
// Directed self-checking bench for dds_chirp_core; expected values are hand-computed.
module tb_dds_chirp_core;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ = 1'b0;
  logic        ACK;
  logic [47:0] DDS_freq = '0;
  logic [47:0] DDS_delta_freq = '0;
  logic [31:0] DDS_delta_rate = '0;
  logic        DDS_start = 1'b0;
  logic [15:0] PHASE_OUT;
  logic [47:0] FREQ_CUR;
  logic        RUNNING;
  logic        SWEEP_TICK;

  int n_vec = 0;
  int n_err = 0;

  dds_chirp_core dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .ACK(ACK),
    .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq),
    .DDS_delta_rate(DDS_delta_rate), .DDS_start(DDS_start),
    .PHASE_OUT(PHASE_OUT), .FREQ_CUR(FREQ_CUR),
    .RUNNING(RUNNING), .SWEEP_TICK(SWEEP_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic capture(input logic [47:0] f, input logic [47:0] d, input logic [31:0] r);
    DDS_freq = f; DDS_delta_freq = d; DDS_delta_rate = r;
    REQ = 1'b1;
    step();
    step();
    REQ = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    n_vec++;
    if ({ACK, RUNNING, SWEEP_TICK, PHASE_OUT, FREQ_CUR} !== 67'd0) begin
      n_err++;
      $display("FAIL reset: ack=%b run=%b tick=%b phase=%h freq=%h, want all 0",
               ACK, RUNNING, SWEEP_TICK, PHASE_OUT, FREQ_CUR);
    end
    RESET = 1'b0;
    step();
  endtask

  task automatic test_handshake();
    DDS_freq = 48'h1000; DDS_delta_freq = 48'h10; DDS_delta_rate = 32'd4;
    REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (ACK !== 1'b1) begin
        n_err++;
        $display("FAIL hs_ack_high[%0d]: got %b want 1", i, ACK);
      end
    end
    REQ = 1'b0;
    step();
    n_vec++;
    if (ACK !== 1'b0) begin
      n_err++;
      $display("FAIL hs_ack_low: got %b want 0", ACK);
    end
    step();
    DDS_freq = 48'h1000;
    REQ = 1'b1;
    step();
    n_vec++;
    if (ACK !== 1'b1) begin
      n_err++;
      $display("FAIL hs_second_ack: got %b want 1", ACK);
    end
    REQ = 1'b0;
    step();
    n_vec++;
    if (ACK !== 1'b0) begin
      n_err++;
      $display("FAIL hs_second_release: got %b want 0", ACK);
    end
  endtask

  task automatic test_constant_tone();
    logic [15:0] exp_ph;
    capture(48'h0100_0000_0000, 48'h123, 32'd0);
    DDS_start = 1'b1;
    step();
    n_vec++;
    if (RUNNING !== 1'b1 || FREQ_CUR !== 48'h0100_0000_0000 || PHASE_OUT !== 16'h0) begin
      n_err++;
      $display("FAIL tone_start: run=%b freq=%h phase=%h want 1/010000000000/0000",
               RUNNING, FREQ_CUR, PHASE_OUT);
    end
    for (int k = 1; k <= 300; k++) begin
      step();
      exp_ph = 16'((k * 256) % 65536);
      n_vec++;
      if (PHASE_OUT !== exp_ph || FREQ_CUR !== 48'h0100_0000_0000 || SWEEP_TICK !== 1'b0) begin
        n_err++;
        $display("FAIL tone_k%0d: phase=%h freq=%h tick=%b want %h/010000000000/0",
                 k, PHASE_OUT, FREQ_CUR, SWEEP_TICK, exp_ph);
      end
    end
    DDS_start = 1'b0;
    step();
    n_vec++;
    if (RUNNING !== 1'b0 || PHASE_OUT !== 16'h0 || FREQ_CUR !== 48'h0100_0000_0000) begin
      n_err++;
      $display("FAIL tone_stop: run=%b phase=%h freq=%h want 0/0000/010000000000",
               RUNNING, PHASE_OUT, FREQ_CUR);
    end
  endtask

  task automatic sweep_run(input string tag, input logic [47:0] f0, input logic [47:0] d);
    logic [47:0] exp_f;
    logic        exp_t;
    capture(f0, d, 32'd4);
    DDS_start = 1'b1;
    step();
    n_vec++;
    if (FREQ_CUR !== f0 || SWEEP_TICK !== 1'b0 || RUNNING !== 1'b1) begin
      n_err++;
      $display("FAIL %s_S0: freq=%h tick=%b run=%b want %h/0/1", tag, FREQ_CUR, SWEEP_TICK, RUNNING, f0);
    end
    exp_f = f0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_t = (k % 4 == 0);
      if (exp_t) exp_f = exp_f + d;
      n_vec++;
      if (FREQ_CUR !== exp_f || SWEEP_TICK !== exp_t) begin
        n_err++;
        $display("FAIL %s_S%0d: freq=%h tick=%b want %h/%b", tag, k, FREQ_CUR, SWEEP_TICK, exp_f, exp_t);
      end
    end
    DDS_start = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    sweep_run("sweep_up", 48'h1000, 48'h10);
    sweep_run("sweep_dn", 48'h1000, 48'hFFFF_FFFF_FFF0);
  endtask

  task automatic test_wrap();
    capture(48'hFFFF_FFFF_FFF8, 48'h10, 32'd1);
    DDS_start = 1'b1;
    step();
    step();
    n_vec++;
    if (FREQ_CUR !== 48'h8 || SWEEP_TICK !== 1'b1 || PHASE_OUT !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_S1: freq=%h tick=%b phase=%h want 000000000008/1/ffff",
               FREQ_CUR, SWEEP_TICK, PHASE_OUT);
    end
    step();
    n_vec++;
    if (FREQ_CUR !== 48'h18 || SWEEP_TICK !== 1'b1 || PHASE_OUT !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap_S2: freq=%h tick=%b phase=%h want 000000000018/1/0000",
               FREQ_CUR, SWEEP_TICK, PHASE_OUT);
    end
    n_vec++;
    if ($isunknown({ACK, RUNNING, SWEEP_TICK, PHASE_OUT, FREQ_CUR})) begin
      n_err++;
      $display("FAIL wrap_noX: outputs contain X/Z freq=%h phase=%h", FREQ_CUR, PHASE_OUT);
    end
    DDS_start = 1'b0;
    step();
  endtask

  task automatic test_shadow_isolation();
    capture(48'h0100_0000_0000, 48'h0, 32'd0);
    DDS_start = 1'b1;
    step();
    step(); step(); step();
    capture(48'h2000, 48'h0, 32'd0);
    n_vec++;
    if (FREQ_CUR !== 48'h0100_0000_0000 || PHASE_OUT !== 16'h0600) begin
      n_err++;
      $display("FAIL shadow_midrun: freq=%h phase=%h want 010000000000/0600", FREQ_CUR, PHASE_OUT);
    end
    DDS_start = 1'b0;
    step();
    DDS_start = 1'b1;
    step();
    n_vec++;
    if (FREQ_CUR !== 48'h2000 || PHASE_OUT !== 16'h0 || RUNNING !== 1'b1) begin
      n_err++;
      $display("FAIL shadow_restart: freq=%h phase=%h run=%b want 000000002000/0000/1",
               FREQ_CUR, PHASE_OUT, RUNNING);
    end
    DDS_start = 1'b0;
    step();
    DDS_freq = 48'h3000;
    REQ = 1'b1;
    DDS_start = 1'b1;
    step();
    n_vec++;
    if (FREQ_CUR !== 48'h2000 || ACK !== 1'b1) begin
      n_err++;
      $display("FAIL shadow_coincident: freq=%h ack=%b want 000000002000/1", FREQ_CUR, ACK);
    end
    REQ = 1'b0;
    DDS_start = 1'b0;
    step();
    DDS_start = 1'b1;
    step();
    n_vec++;
    if (FREQ_CUR !== 48'h3000) begin
      n_err++;
      $display("FAIL shadow_next_rise: freq=%h want 000000003000", FREQ_CUR);
    end
    DDS_start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    capture(48'h0100_0000_0000, 48'h10, 32'd4);
    DDS_start = 1'b1;
    step(); step(); step(); step(); step();
    DDS_freq = 48'h5000; DDS_delta_freq = 48'h0; DDS_delta_rate = 32'd0;
    REQ = 1'b1;
    step();
    RESET = 1'b1;
    DDS_start = 1'b0;
    step();
    n_vec++;
    if ({ACK, RUNNING, SWEEP_TICK, PHASE_OUT, FREQ_CUR} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_mid: ack=%b run=%b tick=%b phase=%h freq=%h, want all 0",
               ACK, RUNNING, SWEEP_TICK, PHASE_OUT, FREQ_CUR);
    end
    RESET = 1'b0;
    step();
    n_vec++;
    if (ACK !== 1'b1) begin
      n_err++;
      $display("FAIL reset_recapture_ack: got %b want 1", ACK);
    end
    REQ = 1'b0;
    step();
    DDS_start = 1'b1;
    step();
    n_vec++;
    if (FREQ_CUR !== 48'h5000 || RUNNING !== 1'b1) begin
      n_err++;
      $display("FAIL reset_recapture_data: freq=%h run=%b want 000000005000/1", FREQ_CUR, RUNNING);
    end
    DDS_start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_constant_tone();
    test_sweep();
    test_wrap();
    test_shadow_isolation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
